// File: rtl/spi_pkg.sv
// Shared types for the SPI slave receiver: FSM state encoding and default word width.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } spi_slv_state_t;

    localparam int SPI_DATA_W_DEF = 8;

endpackage

// File: rtl/spi_slave_shifter.sv
// Shift register with bit counter; done strobes combinationally on the shift that completes a word.
module spi_slave_shifter #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              din,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] word_nxt,
    output logic              dout,
    output logic              mid,
    output logic              done
);
    localparam int unsigned CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // word_nxt is the register contents after this cycle's sample, so the
    // completing bit is already included when done fires.
    generate
        if (MSB_FIRST) begin : g_msb
            assign word_nxt = {sreg_q[DATA_W-2:0], din};
            assign dout     = sreg_q[DATA_W-1];
        end else begin : g_lsb
            assign word_nxt = {din, sreg_q[DATA_W-1:1]};
            assign dout     = sreg_q[0];
        end
    endgenerate

    assign mid  = (cnt_q != '0);
    assign done = shift_en && (cnt_q == CW'(DATA_W - 1));

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
        if (load) begin
            sreg_d = load_data;
        end else if (shift_en) begin
            sreg_d = word_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: FSM plus registered word/strobe outputs.
// Define SPI_SLAVE_MISO_EN to add the tx shift register and miso return path.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = SPI_DATA_W_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              mosi,
`ifdef SPI_SLAVE_MISO_EN
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              miso,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);
    spi_slv_state_t    state_q, state_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              rx_shift, rx_clr, rx_done, rx_mid, shift_exit;
    logic [DATA_W-1:0] rx_word;
    logic              rx_dout_unused;

    spi_slave_shifter #(
        .DATA_W   (DATA_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_rx_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (rx_clr),
        .shift_en (rx_shift),
        .din      (mosi),
        .load     (1'b0),
        .load_data('0),
        .word_nxt (rx_word),
        .dout     (rx_dout_unused),
        .mid      (rx_mid),
        .done     (rx_done)
    );

    always_comb begin
        state_d     = state_q;
        rx_shift    = 1'b0;
        rx_clr      = 1'b0;
        shift_exit  = 1'b0;
        frame_err_d = 1'b0;
        rx_valid_d  = rx_done;
        rx_data_d   = rx_done ? rx_word : rx_data_q;
        case (state_q)
            // Never join a frame already in flight at reset release.
            WAIT_IDLE: begin
                rx_clr = 1'b1;
                if (ss) state_d = IDLE;
            end
            IDLE: begin
                if (!ss) begin
                    rx_shift = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!ss) begin
                    rx_shift = 1'b1;
                end else begin
                    rx_clr      = 1'b1;
                    shift_exit  = 1'b1;
                    frame_err_d = rx_mid;
                    state_d     = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_IDLE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d, tx_ld_data;
    logic [DATA_W-1:0] tx_word_unused;
    logic              tx_acc, tx_ld, tx_done, tx_bit, tx_mid_unused;

    assign tx_ready   = (state_q != SHIFT);
    assign tx_acc     = tx_load && tx_ready;
    assign tx_hold_d  = tx_acc ? tx_data : tx_hold_q;
    // Completed or abandoned frames rearm the tx reg with the last loaded word.
    assign tx_ld      = tx_acc || tx_done || shift_exit;
    assign tx_ld_data = tx_acc ? tx_data : tx_hold_q;

    spi_slave_shifter #(
        .DATA_W   (DATA_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_tx_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (rx_clr),
        .shift_en (rx_shift),
        .din      (1'b0),
        .load     (tx_ld),
        .load_data(tx_ld_data),
        .word_nxt (tx_word_unused),
        .dout     (tx_bit),
        .mid      (tx_mid_unused),
        .done     (tx_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_hold_q <= '0;
        end else begin
            tx_hold_q <= tx_hold_d;
        end
    end

    assign miso = !ss && tx_bit;
`else
    logic shift_exit_unused;
    assign shift_exit_unused = shift_exit;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized scoreboard bench for spi_slave_rx, MSB-first and LSB-first instances side by side.
module tb_spi_slave_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss  = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, frame_err0, frame_err1, busy0, busy1;

    spi_slave_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .ss(ss), .mosi(mosi),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0), .busy(busy0)
    );

    spi_slave_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .ss(ss), .mosi(mosi),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] w_msb;
        logic [7:0] w_lsb;
    } ev_t;

    ev_t        evq[$];
    bit         bits_q[$];
    bit         locked;
    logic       exp_busy;
    logic [7:0] last_msb, last_lsb;
    int         checks = 0;
    int         errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: collect bits of a frame once a quiet ss has been seen,
    // emit a word every 8 bits, an error when ss rises on a partial frame.
    function automatic void model_step(input logic s, input logic m);
        ev_t e;
        if (!locked) begin
            locked   = s;
            exp_busy = 1'b0;
        end else if (!s) begin
            bits_q.push_back(m);
            exp_busy = 1'b1;
            if (bits_q.size() == 8) begin
                e.is_err = 1'b0;
                e.w_msb  = 8'd0;
                e.w_lsb  = 8'd0;
                foreach (bits_q[i]) begin
                    e.w_msb = e.w_msb * 2 + 8'(bits_q[i]);
                    e.w_lsb = e.w_lsb + (8'(bits_q[i]) << i);
                end
                evq.push_back(e);
                bits_q.delete();
            end
        end else begin
            if (bits_q.size() != 0) begin
                e.is_err = 1'b1;
                e.w_msb  = 8'd0;
                e.w_lsb  = 8'd0;
                evq.push_back(e);
            end
            bits_q.delete();
            exp_busy = 1'b0;
        end
    endfunction

    task automatic tick(input logic s, input logic m);
        ss   = s;
        mosi = m;
        @(posedge clk);
        model_step(s, m);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, b[7-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input logic s, input int n);
        rst      = 1'b0;
        ss       = s;
        evq.delete();
        bits_q.delete();
        locked   = 1'b0;
        exp_busy = 1'b0;
        last_msb = 8'd0;
        last_lsb = 8'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (!rst) begin
            chk("reset_outputs_msb", 32'({rx_data0, rx_valid0, frame_err0, busy0}), 32'd0);
            chk("reset_outputs_lsb", 32'({rx_data1, rx_valid1, frame_err1, busy1}), 32'd0);
        end else begin
            chk("busy_msb", 32'(busy0), 32'(exp_busy));
            chk("busy_lsb", 32'(busy1), 32'(exp_busy));
            chk("valid_err_exclusive", 32'(rx_valid0 & frame_err0), 32'd0);
            if (rx_valid0 | frame_err0 | rx_valid1 | frame_err1) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", 32'({rx_valid0, frame_err0, rx_valid1, frame_err1}), 32'd0);
                end else begin
                    e = evq.pop_front();
                    if (e.is_err) begin
                        chk("frame_err_flags", 32'({rx_valid0, frame_err0, rx_valid1, frame_err1}), 32'b0101);
                        chk("err_hold_msb", 32'(rx_data0), 32'(last_msb));
                        chk("err_hold_lsb", 32'(rx_data1), 32'(last_lsb));
                    end else begin
                        chk("valid_flags", 32'({rx_valid0, frame_err0, rx_valid1, frame_err1}), 32'b1010);
                        chk("rx_data_msb", 32'(rx_data0), 32'(e.w_msb));
                        chk("rx_data_lsb", 32'(rx_data1), 32'(e.w_lsb));
                        last_msb = e.w_msb;
                        last_lsb = e.w_lsb;
                    end
                end
            end else begin
                if (evq.size() != 0) begin
                    chk("missing_pulse", 32'(evq.size()), 32'd0);
                    void'(evq.pop_front());
                end
                chk("rx_data_hold_msb", 32'(rx_data0), 32'(last_msb));
                chk("rx_data_hold_lsb", 32'(rx_data1), 32'(last_lsb));
            end
        end
    end

    initial begin
        locked   = 1'b0;
        exp_busy = 1'b0;
        last_msb = 8'd0;
        last_lsb = 8'd0;
        #1;
        do_reset(1'b1, 3);
        idle(2);
        send_bits(8'hA5, 8);
        idle(3);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        idle(2);
        send_bits(8'hFF, 8);
        idle(1);
        send_bits(8'h00, 5);
        idle(3);
        do_reset(1'b0, 3);
        send_bits(8'hB0, 4);
        idle(2);
        send_bits(8'h5A, 8);
        idle(2);
        send_bits(8'h80, 8);
        idle(2);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: send_bits(8'($urandom), 8);
                5: begin
                    send_bits(8'($urandom), 8);
                    send_bits(8'($urandom), 8);
                end
                6: send_bits(8'($urandom), $urandom_range(1, 7));
                7: idle($urandom_range(1, 3));
                8: begin
                    send_bits(8'($urandom), 8);
                    send_bits(8'($urandom), $urandom_range(1, 7));
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) do_reset(1'($urandom_range(0, 1)), 2);
                    else idle(1);
                end
            endcase
            idle($urandom_range(0, 2));
        end
        idle(4);
        chk("queue_drained", 32'(evq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
